// File: rtl/little_alchemy_reg_arbiter.sv
// Round-robin arbiter that lets two simple request/response clients share the
// little_alchemy_controller AXI4-Lite register slave. Each granted request
// becomes exactly one AXI4-Lite write or read; only one is outstanding at once.
module little_alchemy_reg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [1:0]                        req_valid,
  input  logic [1:0]                        req_write,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                        rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic                              grant,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            last_grant_q;
  logic            grant_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            bready_q;
  logic            arvalid_q;
  logic            rready_q;
  logic [1:0]      rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic [1:0]      rsp_resp_q;
  logic            busy_q;

  logic            grant_d;
  logic [AW-1:0]   sel_addr_d;
  logic [DW-1:0]   sel_wdata_d;
  logic            sel_write_d;
  logic            aw_done_d;
  logic            w_done_d;

  // Round-robin pick: on a tie the requester that was not served last wins
  always_comb begin
    grant_d = 1'b0;
    if (req_valid == 2'b11) begin
      grant_d = ~last_grant_q;
    end else if (req_valid[1] && !req_valid[0]) begin
      grant_d = 1'b1;
    end
    sel_addr_d  = grant_d ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    sel_wdata_d = grant_d ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    sel_write_d = grant_d ? req_write[1]         : req_write[0];
    // A channel counts as done once its VALID has dropped or is accepted now
    aw_done_d   = !awvalid_q || M_AXI_AWREADY;
    w_done_d    = !wvalid_q  || M_AXI_WREADY;
  end

  // Transaction FSM; every AXI and response output is a register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            busy_q       <= 1'b1;
            if (sel_write_d) begin
              state_q   <= S_WADDR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WADDR: begin
          // AW and W retire independently, in either order
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            state_q  <= S_WRESP;
            bready_q <= 1'b1;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= M_AXI_BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= S_DONE;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Response is presented for exactly this one cycle
          rsp_rdata_q <= '0;
          rsp_resp_q  <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;
  assign grant         = grant_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_little_alchemy_reg_arbiter.sv
// Bench for little_alchemy_reg_arbiter: two requester agents, a randomized
// AXI4-Lite register slave and a per-request reference of the register file.
module tb_little_alchemy_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, grant;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  little_alchemy_reg_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .grant(grant),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct { bit wr; bit [3:0] addr; bit [31:0] data; } req_t;

  req_t rq0[$], rq1[$];
  int   total = 0, bad = 0, cyc = 0, done_cnt = 0, cnt1 = 0;
  int   order_q[$], rsp_cyc_q[$], rise_q[$];
  logic [31:0] rd_log[$];
  logic [1:0]  last_resp;
  logic [31:0] smem[4], ref_mem[4];

  // slave state
  bit aw_ld, w_ld, ar_ld, aw_got, w_got, b_wait, bvalid_r, r_pend, r_wait, rvalid_r;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int aw_lo = 0, aw_hi = 0, w_lo = 0, w_hi = 0, b_lo = 0, b_hi = 0;
  int ar_lo = 0, ar_hi = 0, r_lo = 0, r_hi = 0;
  bit err_en = 0;
  bit [3:0]  err_addr = 4'h8;
  bit [3:0]  s_awaddr, s_araddr, last_awaddr, last_araddr;
  bit [31:0] s_wdata, last_wdata, rdata_r;
  bit [1:0]  bresp_r;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r, hold_aw, hold_w, hold_ar, prev_any, prev_rsp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: register file updated per completed request in serve order
  task automatic check_rsp(input req_t h, input string tag);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit          err;
    err = h.wr && err_en && (h.addr == err_addr);
    if (h.wr) begin
      if (!err) ref_mem[h.addr[3:2]] = h.data;
      exp_d = 32'h0;
      exp_r = err ? 2'b10 : 2'b00;
    end else begin
      exp_d = ref_mem[h.addr[3:2]];
      exp_r = 2'b00;
      rd_log.push_back(rsp_rdata);
    end
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_resp"}, rsp_resp, exp_r);
    last_resp = rsp_resp;
    done_cnt++;
    rsp_cyc_q.push_back(cyc);
  endtask

  // One clock of the environment, evaluated on the falling edge
  task automatic tick();
    req_t h;
    bit   any;
    @(negedge clk);
    cyc++;
    if (rst) begin
      aw_ld = 0; w_ld = 0; ar_ld = 0; aw_got = 0; w_got = 0; b_wait = 0; bvalid_r = 0;
      r_pend = 0; r_wait = 0; rvalid_r = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      hold_aw = 0; hold_w = 0; hold_ar = 0; prev_any = 0; prev_rsp = 0;
      for (int k = 0; k < 4; k++) begin smem[k] = 32'h0; ref_mem[k] = 32'h0; end
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
      req_valid = 2'b00;
      return;
    end
    // VALID must persist with stable payload until accepted
    if (hold_aw) chk("aw_hold", {awvalid, awaddr}, {1'b1, last_awaddr});
    if (hold_w)  chk("w_hold",  {wvalid, wdata},  {1'b1, last_wdata});
    if (hold_ar) chk("ar_hold", {arvalid, araddr}, {1'b1, last_araddr});
    if (hs_aw) begin aw_got = 1; s_awaddr = last_awaddr; aw_ld = 0; end
    if (hs_w)  begin w_got = 1; s_wdata = last_wdata; w_ld = 0; end
    if (hs_b)  bvalid_r = 0;
    if (hs_ar) begin r_pend = 1; s_araddr = last_araddr; ar_ld = 0; end
    if (hs_r)  rvalid_r = 0;
    if (aw_got && w_got) begin
      if (err_en && s_awaddr == err_addr) bresp_r = 2'b10;
      else begin bresp_r = 2'b00; smem[s_awaddr[3:2]] = s_wdata; end
      aw_got = 0; w_got = 0; b_wait = 1; b_cnt = $urandom_range(b_hi, b_lo);
    end
    if (b_wait) begin
      if (b_cnt == 0) begin b_wait = 0; bvalid_r = 1; end else b_cnt--;
    end
    if (r_pend) begin
      rdata_r = smem[s_araddr[3:2]]; r_pend = 0; r_wait = 1; r_cnt = $urandom_range(r_hi, r_lo);
    end
    if (r_wait) begin
      if (r_cnt == 0) begin r_wait = 0; rvalid_r = 1; end else r_cnt--;
    end
    if (awvalid && !aw_ld && !aw_got) begin aw_ld = 1; aw_cnt = $urandom_range(aw_hi, aw_lo); end
    else if (aw_ld && aw_cnt > 0) aw_cnt--;
    if (wvalid && !w_ld && !w_got) begin w_ld = 1; w_cnt = $urandom_range(w_hi, w_lo); end
    else if (w_ld && w_cnt > 0) w_cnt--;
    if (arvalid && !ar_ld && !r_pend && !r_wait && !rvalid_r) begin
      ar_ld = 1; ar_cnt = $urandom_range(ar_hi, ar_lo);
    end else if (ar_ld && ar_cnt > 0) ar_cnt--;
    awready = aw_ld && aw_cnt == 0;
    wready  = w_ld && w_cnt == 0;
    arready = ar_ld && ar_cnt == 0;
    bvalid  = bvalid_r;
    bresp   = bvalid_r ? bresp_r : 2'b00;
    rvalid  = rvalid_r;
    rdata   = rvalid_r ? rdata_r : 32'h0;
    rresp   = 2'b00;
    // responses back to the requesters
    if (rsp_valid != 2'b00) begin
      chk("rsp_pulse", prev_rsp, 0);
      chk("rsp_onehot", $countones(rsp_valid), 1);
      if (rsp_valid[0]) begin
        if (rq0.size() == 0) chk("rsp0_spurious", 1, 0);
        else begin h = rq0.pop_front(); check_rsp(h, "rsp0"); order_q.push_back(0); end
      end
      if (rsp_valid[1]) begin
        cnt1++;
        if (rq1.size() == 0) chk("rsp1_spurious", 1, 0);
        else begin h = rq1.pop_front(); check_rsp(h, "rsp1"); order_q.push_back(1); end
      end
    end
    prev_rsp = (rsp_valid != 2'b00);
    any = awvalid | wvalid | arvalid;
    if (any && !prev_any) rise_q.push_back(cyc);
    prev_any = any;
    req_valid[0] = rq0.size() > 0;
    if (rq0.size() > 0) begin req_write[0] = rq0[0].wr; req_addr[3:0] = rq0[0].addr; req_wdata[31:0] = rq0[0].data; end
    req_valid[1] = rq1.size() > 0;
    if (rq1.size() > 0) begin req_write[1] = rq1[0].wr; req_addr[7:4] = rq1[0].addr; req_wdata[63:32] = rq1[0].data; end
    hs_aw = awvalid && awready; hold_aw = awvalid && !awready; last_awaddr = awaddr;
    hs_w  = wvalid && wready;   hold_w  = wvalid && !wready;   last_wdata  = wdata;
    hs_ar = arvalid && arready; hold_ar = arvalid && !arready; last_araddr = araddr;
    hs_b  = bvalid && bready;
    hs_r  = rvalid && rready;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    chk("budget", done_cnt, target);
  endtask

  function automatic req_t mk(input bit wr, input bit [3:0] a, input bit [31:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d;
    return r;
  endfunction

  task automatic set_dly(input int lo, input int hi);
    aw_lo = lo; aw_hi = hi; w_lo = lo; w_hi = hi; b_lo = lo; b_hi = hi;
    ar_lo = lo; ar_hi = hi; r_lo = lo; r_hi = hi;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_resp, rsp_rdata}, 0);
    chk({tag, "_busy_grant"}, {busy, grant}, 0);
    chk({tag, "_addr_data"}, {awaddr, araddr, wdata}, 0);
  endtask

  initial begin
    logic [31:0] fair_exp [4];
    int base;
    rst = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_addr = 8'h0; req_wdata = 64'h0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    tick(); tick();
    check_all_zero("reset");
    chk("reset_static", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
    rst = 1'b0;
    tick();

    // single write then read from requester 0, minimum latency
    set_dly(0, 0);
    rq0.push_back(mk(1, 4'h4, 32'hDEADBEEF));
    tick();
    tick();
    chk("wr_busy_valid", {busy, awvalid, wvalid}, 3'b111);
    tick();
    tick();
    chk("wr_latency", rsp_valid, 2'b01);
    chk("wr_resp", rsp_resp, 2'b00);
    rq0.push_back(mk(0, 4'h4, 32'h0));
    tick();
    tick();
    chk("rd_arvalid", {busy, arvalid}, 2'b11);
    tick();
    tick();
    chk("rd_latency", rsp_valid, 2'b01);
    chk("rd_data", rsp_rdata, 32'hDEADBEEF);
    tick();
    chk("rsp1_never", cnt1, 0);

    // simultaneous reads straight after reset
    rst = 1'b1; tick(); rst = 1'b0;
    order_q.delete(); rsp_cyc_q.delete(); rise_q.delete(); rd_log.delete();
    base = done_cnt;
    rq0.push_back(mk(0, 4'h0, 32'h0));
    rq1.push_back(mk(0, 4'h0, 32'h0));
    run_until(base + 2, 40);
    chk("sim_order0", order_q[0], 0);
    chk("sim_order1", order_q[1], 1);
    chk("sim_same_data", rd_log[1], rd_log[0]);
    chk("sim_idle_gap", rise_q[1] - rsp_cyc_q[0], 2);

    // fairness: both requesters hold valid for 8 writes each
    order_q.delete(); rd_log.delete();
    base = done_cnt;
    for (int k = 0; k < 8; k++) begin
      rq0.push_back(mk(1, 4'((k % 4) * 4), 32'hA0000000 + 32'(k)));
      rq1.push_back(mk(1, 4'(((k + 2) % 4) * 4), 32'hB0000000 + 32'(k)));
    end
    run_until(base + 16, 200);
    for (int k = 0; k < 16; k++) chk("fair_order", order_q[k], k % 2);
    for (int k = 0; k < 4; k++) rq0.push_back(mk(0, 4'(k * 4), 32'h0));
    run_until(base + 20, 100);
    fair_exp[0] = 32'hB0000006; fair_exp[1] = 32'hB0000007;
    fair_exp[2] = 32'hA0000006; fair_exp[3] = 32'hA0000007;
    for (int k = 0; k < 4; k++) chk("fair_readback", rd_log[k], fair_exp[k]);

    // error response passes through unchanged
    err_en = 1; err_addr = 4'h8;
    base = done_cnt;
    rq0.push_back(mk(1, 4'h8, 32'h12345678));
    run_until(base + 1, 40);
    chk("err_resp", last_resp, 2'b10);
    tick();
    chk("err_idle", busy, 0);
    err_en = 0;
    rq1.push_back(mk(0, 4'h8, 32'h0));
    run_until(base + 2, 40);
    chk("err_unchanged", rd_log[rd_log.size() - 1], 32'hA0000006);

    // backpressure: forced AW-before-W and W-before-AW, then random mix
    base = done_cnt;
    set_dly(0, 0); aw_lo = 0; aw_hi = 0; w_lo = 3; w_hi = 3;
    rq0.push_back(mk(1, 4'hC, 32'h11111111));
    run_until(base + 1, 40);
    set_dly(0, 0); aw_lo = 3; aw_hi = 3; w_lo = 0; w_hi = 0;
    rq1.push_back(mk(1, 4'h0, 32'h22222222));
    run_until(base + 2, 40);
    set_dly(0, 5);
    for (int k = 0; k < 12; k++) begin
      rq0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom));
      rq1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom));
    end
    run_until(base + 26, 2000);

    // reset in WRESP aborts without a response
    set_dly(0, 0); b_lo = 6; b_hi = 6;
    tick();
    rq1.push_back(mk(1, 4'h4, 32'h33333333));
    begin
      int n = 0;
      while (!bready && n < 30) begin tick(); n++; end
      chk("reach_wresp", bready, 1);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    rq0.delete(); rq1.delete();
    base = done_cnt;
    for (int k = 0; k < 3; k++) begin tick(); chk("reset_no_rsp", rsp_valid, 0); end
    rst = 1'b0;
    set_dly(0, 0);
    order_q.delete();
    tick();
    chk("post_reset_no_rsp", done_cnt, base);
    rq0.push_back(mk(0, 4'h4, 32'h0));
    rq1.push_back(mk(0, 4'h4, 32'h0));
    run_until(base + 2, 40);
    chk("post_reset_tie", order_q[0], 0);
    chk("post_reset_data", rd_log[rd_log.size() - 1], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
